// File: rtl/eth_parser_pkg.sv
// Shared types and constants for the Ethernet/IPv4/UDP receive parser.
package eth_parser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ETH,
    ST_IP,
    ST_UDP,
    ST_PAYLOAD,
    ST_DRAIN
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_ETHERTYPE = 3'd1,
    ERR_VER_IHL   = 3'd2,
    ERR_PROTO     = 3'd3,
    ERR_PORT      = 3'd4,
    ERR_UDP_LEN   = 3'd5,
    ERR_TRUNC     = 3'd6
  } err_code_t;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD            = 8'hD5;
  localparam logic [5:0]  ETH_HDR_LEN    = 6'd14;
  localparam logic [5:0]  IP_HDR_LEN     = 6'd20;
  localparam logic [5:0]  UDP_HDR_LEN    = 6'd8;
  localparam logic [15:0] UDP_MIN_LEN    = 16'd8;

endpackage

// File: rtl/eth_parser_stats.sv
// Accepted-frame and dropped-frame counters for the receive parser; both wrap.
module eth_parser_stats #(
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hdr_valid,
  input  logic              err,
  output logic [STAT_W-1:0] frame_cnt,
  output logic [STAT_W-1:0] drop_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (hdr_valid) frame_cnt <= frame_cnt + 1'b1;
      if (err)       drop_cnt  <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/eth_udp_parser.sv
// Preamble hunt plus Ethernet II / IPv4 / UDP header walk emitting the UDP payload.
// Define PARSER_STATS_EN to add the frame_cnt/drop_cnt statistics ports.
module eth_udp_parser
  import eth_parser_pkg::*;
#(
  parameter int          PREAMBLE_LEN = 7,
  parameter logic [15:0] DST_PORT     = 16'd0,
  parameter int          STAT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic [7:0]        m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  output logic              hdr_valid,
  output logic [15:0]       hdr_src_port,
  output logic [15:0]       hdr_dst_port,
  output logic [15:0]       payload_len,
  output logic              err,
  output logic [2:0]        err_code
`ifdef PARSER_STATS_EN
  ,
  output logic [STAT_W-1:0] frame_cnt,
  output logic [STAT_W-1:0] drop_cnt
`endif
);

  localparam logic [3:0] PRE_MIN = 4'(PREAMBLE_LEN);

  state_t      state_q, state_d;
  logic [5:0]  hdr_cnt_q, hdr_cnt_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
  logic [15:0] pay_cnt_q, pay_cnt_d;
  logic [15:0] plen;
  err_code_t   err_code_q, err_code_d, chk_code;
  logic        chk_fail, seg_end, in_hdr;
  state_t      seg_next;
  logic        fwd, fwd_last, hdr_fire, err_fire;

  assign plen     = len_q - UDP_MIN_LEN;
  assign err_code = err_code_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      hdr_cnt_q <= '0;
      pre_cnt_q <= '0;
      hi_q      <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      pay_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      pre_cnt_q <= pre_cnt_d;
      hi_q      <= hi_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      pay_cnt_q <= pay_cnt_d;
    end
  end

  // Header states only flag check results; the shared tail below decides error/advance.
  always_comb begin
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    pre_cnt_d  = pre_cnt_q;
    hi_d       = hi_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    pay_cnt_d  = pay_cnt_q;
    chk_fail   = 1'b0;
    chk_code   = ERR_NONE;
    seg_end    = 1'b0;
    seg_next   = ST_IDLE;
    in_hdr     = 1'b0;
    fwd        = 1'b0;
    fwd_last   = 1'b0;
    hdr_fire   = 1'b0;
    err_fire   = 1'b0;
    err_code_d = ERR_NONE;
    if (s_tvalid) begin
      hdr_cnt_d = hdr_cnt_q + 6'd1;
      unique case (state_q)
        ST_IDLE: begin
          if (s_tlast) begin
            pre_cnt_d = '0;
          end else if (s_tdata == PREAMBLE_BYTE) begin
            pre_cnt_d = (pre_cnt_q == 4'd15) ? 4'd15 : pre_cnt_q + 4'd1;
          end else if (s_tdata == SFD && pre_cnt_q >= PRE_MIN) begin
            pre_cnt_d = '0;
            state_d   = ST_ETH;
          end else begin
            pre_cnt_d = '0;
          end
        end
        ST_ETH: begin
          in_hdr   = 1'b1;
          seg_end  = (hdr_cnt_q == ETH_HDR_LEN - 6'd1);
          seg_next = ST_IP;
          if (hdr_cnt_q == 6'd12) hi_d = s_tdata;
          if (seg_end && {hi_q, s_tdata} != ETHERTYPE_IPV4) begin
            chk_fail = 1'b1;
            chk_code = ERR_ETHERTYPE;
          end
        end
        ST_IP: begin
          in_hdr   = 1'b1;
          seg_end  = (hdr_cnt_q == IP_HDR_LEN - 6'd1);
          seg_next = ST_UDP;
          if (hdr_cnt_q == 6'd0 && s_tdata != IP_VER_IHL) begin
            chk_fail = 1'b1;
            chk_code = ERR_VER_IHL;
          end
          if (hdr_cnt_q == 6'd9 && s_tdata != IP_PROTO_UDP) begin
            chk_fail = 1'b1;
            chk_code = ERR_PROTO;
          end
        end
        ST_UDP: begin
          in_hdr   = 1'b1;
          seg_end  = (hdr_cnt_q == UDP_HDR_LEN - 6'd1);
          seg_next = (len_q == UDP_MIN_LEN) ? ST_DRAIN : ST_PAYLOAD;
          case (hdr_cnt_q)
            6'd0, 6'd2, 6'd4: hi_d = s_tdata;
            6'd1: src_d = {hi_q, s_tdata};
            6'd3: begin
              dst_d = {hi_q, s_tdata};
              if (DST_PORT != 16'd0 && {hi_q, s_tdata} != DST_PORT) begin
                chk_fail = 1'b1;
                chk_code = ERR_PORT;
              end
            end
            6'd5: begin
              len_d = {hi_q, s_tdata};
              if ({hi_q, s_tdata} < UDP_MIN_LEN) begin
                chk_fail = 1'b1;
                chk_code = ERR_UDP_LEN;
              end
            end
            default: ;
          endcase
        end
        ST_PAYLOAD: begin
          fwd       = 1'b1;
          pay_cnt_d = pay_cnt_q + 16'd1;
          if (pay_cnt_q == plen - 16'd1) begin
            fwd_last = 1'b1;
            state_d  = s_tlast ? ST_IDLE : ST_DRAIN;
          end else if (s_tlast) begin
            fwd_last   = 1'b1;
            err_fire   = 1'b1;
            err_code_d = ERR_TRUNC;
            state_d    = ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (s_tlast) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
      if (in_hdr) begin
        if (chk_fail) begin
          err_fire   = 1'b1;
          err_code_d = chk_code;
          state_d    = s_tlast ? ST_IDLE : ST_DRAIN;
        end else if (s_tlast) begin
          err_fire   = 1'b1;
          err_code_d = ERR_TRUNC;
          state_d    = ST_IDLE;
        end else if (seg_end) begin
          state_d  = seg_next;
          hdr_fire = (state_q == ST_UDP);
        end
      end
      if (state_d != state_q) begin
        hdr_cnt_d = '0;
        pay_cnt_d = '0;
      end
    end
  end

  // Single register stage on every output; header fields and err_code hold between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tdata      <= '0;
      m_tvalid     <= 1'b0;
      m_tlast      <= 1'b0;
      hdr_valid    <= 1'b0;
      hdr_src_port <= '0;
      hdr_dst_port <= '0;
      payload_len  <= '0;
      err          <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      m_tvalid  <= fwd;
      m_tlast   <= fwd_last;
      hdr_valid <= hdr_fire;
      err       <= err_fire;
      if (fwd) m_tdata <= s_tdata;
      if (hdr_fire) begin
        hdr_src_port <= src_q;
        hdr_dst_port <= dst_q;
        payload_len  <= plen;
      end
      if (err_fire) err_code_q <= err_code_d;
    end
  end

`ifdef PARSER_STATS_EN
  eth_parser_stats #(.STAT_W(STAT_W)) u_stats (
    .clk       (clk),
    .rst_n     (rst_n),
    .hdr_valid (hdr_valid),
    .err       (err),
    .frame_cnt (frame_cnt),
    .drop_cnt  (drop_cnt)
  );
`else
  logic unused_stat_w;
  assign unused_stat_w = (STAT_W > 0);
`endif

endmodule

// File: tb/tb_eth_udp_parser.sv
// Self-checking bench for eth_udp_parser: directed frames then randomized frames
// scored against a byte-offset reference model of the frame format.
module tb_eth_udp_parser;

   localparam int          PRE  = 7;
   localparam logic [15:0] PORT = 16'd5000;
   localparam int          SW   = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  s_tdata;
   logic        s_tvalid, s_tlast;
   logic [7:0]  m_tdata;
   logic        m_tvalid, m_tlast, hdr_valid, err;
   logic [15:0] hdr_src_port, hdr_dst_port, payload_len;
   logic [2:0]  err_code;
`ifdef PARSER_STATS_EN
   logic [SW-1:0] frame_cnt, drop_cnt;
`endif

   // Free-running clock with a 10 time-unit period.
   always #5 clk = ~clk;

   eth_udp_parser #(.PREAMBLE_LEN(PRE), .DST_PORT(PORT), .STAT_W(SW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_tdata      (s_tdata),
      .s_tvalid     (s_tvalid),
      .s_tlast      (s_tlast),
      .m_tdata      (m_tdata),
      .m_tvalid     (m_tvalid),
      .m_tlast      (m_tlast),
      .hdr_valid    (hdr_valid),
      .hdr_src_port (hdr_src_port),
      .hdr_dst_port (hdr_dst_port),
      .payload_len  (payload_len),
      .err          (err),
      .err_code     (err_code)
`ifdef PARSER_STATS_EN
      ,
      .frame_cnt    (frame_cnt),
      .drop_cnt     (drop_cnt)
`endif
   );

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0]  frm[$];
   logic [7:0]  got_pay[$];
   logic        exp_mv[0:255], exp_ml[0:255], exp_hv[0:255], exp_er[0:255];
   logic [7:0]  exp_md[0:255];
   logic [2:0]  exp_ec[0:255];
   logic [15:0] exp_src, exp_dst, exp_plen;
   logic [2:0]  hold_code;
   logic [15:0] hold_src, hold_dst, hold_plen;
   int          cnt_frames, cnt_drops;

   // Bookkeeping for one comparison result: count it and report a mismatch.
   task automatic checkResult(input string tag, input bit ok,
                              input logic [63:0] obs, input logic [63:0] expv);
      n_assert++;
      if (!ok) begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [7:0] b(input int idx);
      return (idx < frm.size()) ? frm[idx] : 8'h00;
   endfunction

   // Reference model: locate the SFD, then judge each field by its byte offset from it.
   function automatic void modelFrame();
      int n, run, h, code, plen, idx;
      n = frm.size();
      run = 0;
      h = -1;
      for (int i = 0; i < 256; i++) begin
         exp_mv[i] = 0; exp_ml[i] = 0; exp_hv[i] = 0; exp_er[i] = 0;
         exp_md[i] = 0; exp_ec[i] = 0;
      end
      for (int i = 0; i < n; i++) begin
         if (i == n - 1) break;
         if (frm[i] == 8'h55) run++;
         else if (frm[i] == 8'hD5 && run >= PRE) begin h = i + 1; break; end
         else run = 0;
      end
      if (h < 0) return;
      for (int o = 0; o < 42; o++) begin
         idx = h + o;
         code = 0;
         if (o == 13 && {b(h+12), b(h+13)} != 16'h0800) code = 1;
         else if (o == 14 && b(h+14) != 8'h45) code = 2;
         else if (o == 23 && b(h+23) != 8'h11) code = 3;
         else if (o == 37 && PORT != 16'd0 && {b(h+36), b(h+37)} != PORT) code = 4;
         else if (o == 39 && {b(h+38), b(h+39)} < 16'd8) code = 5;
         else if (idx == n - 1) code = 6;
         if (code != 0) begin
            exp_er[idx] = 1;
            exp_ec[idx] = 3'(code);
            return;
         end
      end
      exp_hv[h+41] = 1;
      exp_src  = {b(h+34), b(h+35)};
      exp_dst  = {b(h+36), b(h+37)};
      exp_plen = {b(h+38), b(h+39)} - 16'd8;
      plen = int'(exp_plen);
      for (int j = 0; j < plen; j++) begin
         idx = h + 42 + j;
         exp_mv[idx] = 1;
         exp_md[idx] = b(idx);
         if (j == plen - 1 || idx == n - 1) exp_ml[idx] = 1;
         if (idx == n - 1 && j < plen - 1) begin
            exp_er[idx] = 1;
            exp_ec[idx] = 3'd6;
         end
         if (idx == n - 1) break;
      end
   endfunction

   task automatic buildFrame(input int npre, input logic [15:0] etype, input logic [7:0] vihl,
                             input logic [7:0] proto, input logic [15:0] dport,
                             input logic [15:0] ulen, input int npay, input int ntail);
      frm.delete();
      repeat (npre) frm.push_back(8'h55);
      frm.push_back(8'hD5);
      repeat (12) frm.push_back(8'($urandom));
      frm.push_back(etype[15:8]); frm.push_back(etype[7:0]);
      frm.push_back(vihl);
      repeat (8) frm.push_back(8'($urandom));
      frm.push_back(proto);
      repeat (10) frm.push_back(8'($urandom));
      repeat (2) frm.push_back(8'($urandom));
      frm.push_back(dport[15:8]); frm.push_back(dport[7:0]);
      frm.push_back(ulen[15:8]);  frm.push_back(ulen[7:0]);
      repeat (2) frm.push_back(8'($urandom));
      repeat (npay) frm.push_back(8'($urandom));
      repeat (ntail) frm.push_back(8'($urandom));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input int k, input bit active);
      logic ev, el, eh, ee;
      logic [7:0] ed;
      ev = active ? exp_mv[k] : 1'b0;
      el = active ? exp_ml[k] : 1'b0;
      eh = active ? exp_hv[k] : 1'b0;
      ee = active ? exp_er[k] : 1'b0;
      ed = exp_md[k];
      if (ee) begin hold_code = exp_ec[k]; cnt_drops++; end
      if (eh) begin hold_src = exp_src; hold_dst = exp_dst; hold_plen = exp_plen; cnt_frames++; end
      checkResult("m_tvalid", m_tvalid === ev, m_tvalid, ev);
      checkResult("m_tlast", m_tlast === el, m_tlast, el);
      if (ev) checkResult("m_tdata", m_tdata === ed, m_tdata, ed);
      checkResult("hdr_valid", hdr_valid === eh, hdr_valid, eh);
      checkResult("err", err === ee, err, ee);
      checkResult("err_code", err_code === hold_code, err_code, hold_code);
      checkResult("hdr_src_port", hdr_src_port === hold_src, hdr_src_port, hold_src);
      checkResult("hdr_dst_port", hdr_dst_port === hold_dst, hdr_dst_port, hold_dst);
      checkResult("payload_len", payload_len === hold_plen, payload_len, hold_plen);
      if (m_tvalid) got_pay.push_back(m_tdata);
   endtask

   task automatic applyStimulus(input int first, input int last);
      for (int k = first; k <= last; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            s_tvalid = 1'b0;
            s_tdata  = 8'($urandom);
            s_tlast  = 1'($urandom_range(0, 1));
            step();
            checkOutput(k, 1'b0);
         end
         s_tvalid = 1'b1;
         s_tdata  = frm[k];
         s_tlast  = (k == frm.size() - 1);
         step();
         checkOutput(k, 1'b1);
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      repeat (n) begin
         step();
         checkOutput(0, 1'b0);
      end
   endtask

   task automatic checkStats();
`ifdef PARSER_STATS_EN
      checkResult("frame_cnt", frame_cnt === SW'(cnt_frames), frame_cnt, SW'(cnt_frames));
      checkResult("drop_cnt", drop_cnt === SW'(cnt_drops), drop_cnt, SW'(cnt_drops));
`endif
   endtask

   task automatic runFrame();
      modelFrame();
      applyStimulus(0, frm.size() - 1);
      idleCycles(2);
      checkStats();
   endtask

   task automatic clearHolds();
      hold_code = 0; hold_src = 0; hold_dst = 0; hold_plen = 0;
      cnt_frames = 0; cnt_drops = 0;
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int kind, npre, npay, cut;
      logic [15:0] etype, dport, ulen;
      logic [7:0]  vihl, proto;

      rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00;
      clearHolds();
      repeat (2) step();
      checkResult("reset m_tvalid", m_tvalid === 1'b0, m_tvalid, 1'b0);
      checkResult("reset m_tdata", m_tdata === 8'h00, m_tdata, 8'h00);
      checkResult("reset m_tlast", m_tlast === 1'b0, m_tlast, 1'b0);
      checkResult("reset hdr_valid", hdr_valid === 1'b0, hdr_valid, 1'b0);
      checkResult("reset err", err === 1'b0, err, 1'b0);
      checkResult("reset err_code", err_code === 3'd0, err_code, 3'd0);
      checkResult("reset payload_len", payload_len === 16'd0, payload_len, 16'd0);
      rst_n = 1'b1;
      idleCycles(2);
      checkStats();

      // Reference frame: port 5000, UDP length 12, payload DE AD BE EF, then FCS.
      buildFrame(7, 16'h0800, 8'h45, 8'h11, 16'd5000, 16'd12, 4, 4);
      frm[50] = 8'hDE; frm[51] = 8'hAD; frm[52] = 8'hBE; frm[53] = 8'hEF;
      got_pay.delete();
      runFrame();
      checkResult("pay_count", got_pay.size() === 4, got_pay.size(), 4);
      if (got_pay.size() == 4) begin
         checkResult("pay0", got_pay[0] === 8'hDE, got_pay[0], 8'hDE);
         checkResult("pay3", got_pay[3] === 8'hEF, got_pay[3], 8'hEF);
      end
      checkResult("plen_direct", payload_len === 16'd4, payload_len, 16'd4);
      checkResult("dst_direct", hdr_dst_port === 16'd5000, hdr_dst_port, 16'd5000);

      buildFrame(7, 16'h86DD, 8'h45, 8'h11, 16'd5000, 16'd12, 4, 4);
      runFrame();
      checkResult("ethertype code", err_code === 3'd1, err_code, 3'd1);
      buildFrame(7, 16'h0800, 8'h45, 8'h11, 16'd5000, 16'd10, 2, 4);
      runFrame();

      buildFrame(7, 16'h0800, 8'h45, 8'h11, 16'd6000, 16'd12, 4, 4);
      runFrame();
      checkResult("port code", err_code === 3'd4, err_code, 3'd4);

      buildFrame(6, 16'h0800, 8'h45, 8'h11, 16'd5000, 16'd12, 4, 4);
      runFrame();
      buildFrame(9, 16'h0800, 8'h45, 8'h11, 16'd5000, 16'd12, 4, 4);
      runFrame();

      buildFrame(7, 16'h0800, 8'h45, 8'h11, 16'd5000, 16'd12, 2, 0);
      runFrame();
      checkResult("trunc code", err_code === 3'd6, err_code, 3'd6);

      buildFrame(7, 16'h0800, 8'h45, 8'h11, 16'd5000, 16'd8, 0, 4);
      runFrame();
      checkResult("zero plen", payload_len === 16'd0, payload_len, 16'd0);

      // Reset in the middle of the IP header; the remainder must be hunted as preamble.
      buildFrame(7, 16'h0800, 8'h45, 8'h11, 16'd5000, 16'd12, 4, 4);
      modelFrame();
      applyStimulus(0, 27);
      rst_n = 1'b0;
      #2;
      checkResult("midrst m_tvalid", m_tvalid === 1'b0, m_tvalid, 1'b0);
      checkResult("midrst hdr_src_port", hdr_src_port === 16'd0, hdr_src_port, 16'd0);
      checkResult("midrst hdr_dst_port", hdr_dst_port === 16'd0, hdr_dst_port, 16'd0);
      checkResult("midrst err_code", err_code === 3'd0, err_code, 3'd0);
      checkResult("midrst payload_len", payload_len === 16'd0, payload_len, 16'd0);
      step();
      rst_n = 1'b1;
      clearHolds();
      frm = frm[28:$];
      runFrame();
      buildFrame(8, 16'h0800, 8'h45, 8'h11, 16'd5000, 16'd14, 6, 4);
      runFrame();

      for (int f = 0; f < 40; f++) begin
         kind  = $urandom_range(0, 9);
         npre  = (kind == 7) ? $urandom_range(0, 6) : $urandom_range(7, 15);
         etype = (kind == 1) ? 16'($urandom) : 16'h0800;
         vihl  = (kind == 2) ? 8'h46 : 8'h45;
         proto = (kind == 3) ? 8'h06 : 8'h11;
         dport = (kind == 4) ? 16'd6000 : 16'd5000;
         npay  = $urandom_range(0, 20);
         ulen  = (kind == 5) ? 16'($urandom_range(0, 7)) : 16'(8 + npay);
         buildFrame(npre, etype, vihl, proto, dport, ulen, npay, $urandom_range(4, 8));
         if (kind == 6) begin
            cut = $urandom_range(npre + 1, frm.size() - 2);
            frm = frm[0:cut];
         end
         runFrame();
      end

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
